// File: rtl/slot_spin_controller.sv
// rtl/slot_spin_controller.sv - slot machine game sequencer: credits, spin gating, scoring, payout
module slot_spin_controller #(
    parameter int unsigned SPIN_CYCLES  = 8,
    parameter int unsigned CREDIT_W     = 8,
    parameter int unsigned JACKPOT_MULT = 10,
    parameter int unsigned TRIPLE_MULT  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_in,
    input  logic                spin_req,
    input  logic [1:0]          bet,
    input  logic [2:0]          rng1,
    input  logic [2:0]          rng2,
    input  logic [2:0]          rng3,
    output logic                rng_step,
    output logic                busy,
    output logic [CREDIT_W-1:0] credits,
    output logic [2:0]          reel1,
    output logic [2:0]          reel2,
    output logic [2:0]          reel3,
    output logic [CREDIT_W-1:0] payout,
    output logic [1:0]          win_type,
    output logic                win_valid,
    output logic                reject
);

    typedef enum logic [2:0] {IDLE, SPIN, SETTLE, EVAL, RESULT} state_t;

    localparam int unsigned          PW         = CREDIT_W + 34;
    localparam logic [CREDIT_W-1:0]  CREDIT_MAX = '1;

    state_t                state;
    logic [7:0]            spin_cnt;
    logic [1:0]            bet_lat;
    logic [1:0]            bet_eff;
    logic                  accept;
    logic [CREDIT_W-1:0]   debit;
    logic [CREDIT_W-1:0]   payout_add;
    logic [CREDIT_W+1:0]   credit_sum;
    logic [CREDIT_W-1:0]   credits_next;
    logic                  all_equal;
    logic                  any_pair;

    function automatic logic [CREDIT_W-1:0] sat_mul(input logic [1:0] b, input int unsigned m);
        logic [PW-1:0] p;
        p = PW'(b) * PW'(m);
        if (p > PW'(CREDIT_MAX))
            return CREDIT_MAX;
        return p[CREDIT_W-1:0];
    endfunction

    always_comb begin
        bet_eff      = (bet == 2'd0) ? 2'd1 : bet;
        accept       = (state == IDLE) && spin_req && (credits >= CREDIT_W'(bet_eff));
        debit        = accept ? CREDIT_W'(bet_eff) : '0;
        payout_add   = (state == RESULT) ? payout : '0;
        // Debit is guarded by accept, so adding first and subtracting last never wraps.
        credit_sum   = (CREDIT_W+2)'(credits) + (CREDIT_W+2)'(coin_in)
                     + (CREDIT_W+2)'(payout_add) - (CREDIT_W+2)'(debit);
        credits_next = (credit_sum > (CREDIT_W+2)'(CREDIT_MAX)) ? CREDIT_MAX
                                                                : credit_sum[CREDIT_W-1:0];
        all_equal    = (rng1 == rng2) && (rng2 == rng3);
        any_pair     = (rng1 == rng2) || (rng2 == rng3) || (rng1 == rng3);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            spin_cnt  <= '0;
            bet_lat   <= '0;
            credits   <= '0;
            reel1     <= '0;
            reel2     <= '0;
            reel3     <= '0;
            payout    <= '0;
            win_type  <= '0;
            rng_step  <= 1'b0;
            busy      <= 1'b0;
            win_valid <= 1'b0;
            reject    <= 1'b0;
        end else begin
            credits   <= credits_next;
            reject    <= 1'b0;
            win_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        bet_lat  <= bet_eff;
                        spin_cnt <= 8'(SPIN_CYCLES);
                        rng_step <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SPIN;
                    end else if (spin_req) begin
                        reject <= 1'b1;
                    end
                end
                SPIN: begin
                    spin_cnt <= spin_cnt - 8'd1;
                    if (spin_cnt == 8'd1) begin
                        rng_step <= 1'b0;
                        state    <= SETTLE;
                    end
                end
                SETTLE: state <= EVAL;
                EVAL: begin
                    reel1 <= rng1;
                    reel2 <= rng2;
                    reel3 <= rng3;
                    if (all_equal && rng1 == 3'd7) begin
                        win_type <= 2'd3;
                        payout   <= sat_mul(bet_lat, JACKPOT_MULT);
                    end else if (all_equal) begin
                        win_type <= 2'd2;
                        payout   <= sat_mul(bet_lat, TRIPLE_MULT);
                    end else if (any_pair) begin
                        win_type <= 2'd1;
                        payout   <= CREDIT_W'(bet_lat);
                    end else begin
                        win_type <= 2'd0;
                        payout   <= '0;
                    end
                    win_valid <= 1'b1;
                    state     <= RESULT;
                end
                RESULT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
